// File: rtl/avst_packet_summer.sv
// Avalon-ST packet checksum: sums each input packet into SUM_W bits and emits
// the sum as SUM_W/DATA_W output beats, with one packet of overlap via a hold register.
module avst_packet_summer #(
   parameter int DATA_W    = 8,
   parameter int SUM_W     = 32,
   parameter int MSB_FIRST = 1,
   parameter int SATURATE  = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] data_in,
   input  logic              end_in,
   input  logic              valid_in,
   output logic              ready_in,
   output logic [DATA_W-1:0] data_out,
   output logic              end_out,
   output logic              valid_out,
   input  logic              ready_out,
   output logic              error_out
);

   localparam int NBEATS = SUM_W / DATA_W;
   localparam int IDX_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;

   typedef enum logic {IDLE, SEND} state_t;

   state_t             state, state_n;
   logic [SUM_W-1:0]   acc, hold_sum, sum_q, final_sum;
   logic               ovf, hold_ovf, ovf_q, held, final_ovf;
   logic [IDX_W-1:0]   idx;
   logic [SUM_W:0]     add;
   logic [DATA_W-1:0]  beat;
   logic               in_xfer, out_xfer, last_beat, load_new, load_hold;

   assign add       = {1'b0, acc} + {{(SUM_W-DATA_W+1){1'b0}}, data_in};
   assign final_sum = (SATURATE != 0 && add[SUM_W]) ? {SUM_W{1'b1}} : add[SUM_W-1:0];
   assign final_ovf = ovf | add[SUM_W];

   assign ready_in  = !held;
   assign in_xfer   = valid_in && !held;
   assign valid_out = (state == SEND);
   assign out_xfer  = valid_out && ready_out;
   assign last_beat = (idx == IDX_W'(NBEATS-1));

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   // A finishing last beat frees the serializer in the same cycle, so a parked
   // sum or a freshly ended packet reloads it with no bubble.
   always_comb begin
      state_n   = state;
      load_new  = 1'b0;
      load_hold = 1'b0;
      case (state)
         IDLE: begin
            if (in_xfer && end_in) begin
               load_new = 1'b1;
               state_n  = SEND;
            end
         end
         SEND: begin
            if (out_xfer && last_beat) begin
               if (held)                  load_hold = 1'b1;
               else if (in_xfer && end_in) load_new  = 1'b1;
               else                        state_n   = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         acc      <= '0;
         ovf      <= 1'b0;
         hold_sum <= '0;
         hold_ovf <= 1'b0;
         held     <= 1'b0;
         sum_q    <= '0;
         ovf_q    <= 1'b0;
         idx      <= '0;
      end else begin
         if (in_xfer) begin
            if (end_in) begin
               acc <= '0;
               ovf <= 1'b0;
               if (!load_new) begin
                  hold_sum <= final_sum;
                  hold_ovf <= final_ovf;
                  held     <= 1'b1;
               end
            end else begin
               acc <= final_sum;
               ovf <= final_ovf;
            end
         end
         if (load_new) begin
            sum_q <= final_sum;
            ovf_q <= final_ovf;
         end else if (load_hold) begin
            sum_q <= hold_sum;
            ovf_q <= hold_ovf;
            held  <= 1'b0;
         end
         if (load_new || load_hold) idx <= '0;
         else if (out_xfer)         idx <= last_beat ? '0 : idx + 1'b1;
      end
   end

   always_comb begin
      beat = '0;
      for (int k = 0; k < NBEATS; k++) begin
         if (idx == IDX_W'(k))
            beat = (MSB_FIRST != 0) ? sum_q[SUM_W-1-k*DATA_W -: DATA_W]
                                    : sum_q[k*DATA_W +: DATA_W];
      end
   end

   assign data_out  = valid_out ? beat : '0;
   assign end_out   = valid_out && last_beat;
   assign error_out = valid_out && last_beat && ovf_q;

endmodule

// File: tb/tb_avst_packet_summer.sv
// Bench for avst_packet_summer: four parameter variants, vector table plus
// stall, overlap, random-backpressure and reset sequences.
module tb_avst_packet_summer;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] data_in = 8'h00;
   logic       end_in = 1'b0;
   logic       vin [4];
   logic       rout [4];
   logic [7:0] dout [4];
   logic       eo [4], vo [4], ri [4], er [4];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int end_cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   avst_packet_summer #(.DATA_W(8), .SUM_W(32), .MSB_FIRST(1), .SATURATE(0)) u0 (
      .clk(clk), .reset(reset), .data_in(data_in), .end_in(end_in), .valid_in(vin[0]),
      .ready_in(ri[0]), .data_out(dout[0]), .end_out(eo[0]), .valid_out(vo[0]),
      .ready_out(rout[0]), .error_out(er[0]));
   avst_packet_summer #(.DATA_W(8), .SUM_W(32), .MSB_FIRST(0), .SATURATE(0)) u1 (
      .clk(clk), .reset(reset), .data_in(data_in), .end_in(end_in), .valid_in(vin[1]),
      .ready_in(ri[1]), .data_out(dout[1]), .end_out(eo[1]), .valid_out(vo[1]),
      .ready_out(rout[1]), .error_out(er[1]));
   avst_packet_summer #(.DATA_W(8), .SUM_W(8), .MSB_FIRST(1), .SATURATE(0)) u2 (
      .clk(clk), .reset(reset), .data_in(data_in), .end_in(end_in), .valid_in(vin[2]),
      .ready_in(ri[2]), .data_out(dout[2]), .end_out(eo[2]), .valid_out(vo[2]),
      .ready_out(rout[2]), .error_out(er[2]));
   avst_packet_summer #(.DATA_W(8), .SUM_W(8), .MSB_FIRST(1), .SATURATE(1)) u3 (
      .clk(clk), .reset(reset), .data_in(data_in), .end_in(end_in), .valid_in(vin[3]),
      .ready_in(ri[3]), .data_out(dout[3]), .end_out(eo[3]), .valid_out(vo[3]),
      .ready_out(rout[3]), .error_out(er[3]));

   typedef struct packed {
      logic [7:0] d;
      logic       e;
      logic       r;
   } beat_t;

   beat_t q [4][$];
   int    qc [4][$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Output monitor: a beat counts when valid && ready at the negedge before the edge.
   logic  stall_p = 1'b0;
   beat_t prev;
   always @(negedge clk) begin
      if (!reset) begin
         for (int k = 0; k < 4; k++) begin
            if (vo[k] && rout[k]) begin
               q[k].push_back('{dout[k], eo[k], er[k]});
               qc[k].push_back(cyc + 1);
            end
         end
         if (stall_p)
            chk("stall_hold", {vo[0], dout[0], eo[0], er[0]}, {1'b1, prev});
      end
      stall_p = !reset && vo[0] && !rout[0];
      prev    = '{dout[0], eo[0], er[0]};
   end

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic send_beat(input int sel, input logic [7:0] d, input logic e);
      logic ok;
      data_in  = d;
      end_in   = e;
      vin[sel] = 1'b1;
      ok = 1'b0;
      for (int t = 0; t < 200 && !ok; t++) begin
         @(negedge clk);
         if (ri[sel]) begin
            ok = 1'b1;
            if (e) end_cyc = cyc + 1;
         end
      end
      chk("accept_in_time", {63'd0, ok}, 64'd1);
      @(posedge clk);
      #1;
      vin[sel] = 1'b0;
      end_in   = 1'b0;
   endtask

   task automatic send_pkt(input int sel, input int n, input logic [31:0] v);
      for (int i = 0; i < n; i++) send_beat(sel, v[31-8*i -: 8], (i == n-1));
   endtask

   task automatic wait_beats(input int sel, input int n, input int bound);
      for (int t = 0; t < bound && q[sel].size() < n; t++) @(negedge clk);
      repeat (6) @(posedge clk);
      #1;
      chk($sformatf("beat_count_dut%0d", sel), q[sel].size(), n);
   endtask

   task automatic clear_q;
      for (int k = 0; k < 4; k++) begin
         q[k].delete();
         qc[k].delete();
      end
   endtask

   typedef struct {
      int          sel;
      int          nin;
      logic [31:0] din;
      int          nout;
      logic [31:0] dexp;
      logic        err;
   } vec_t;

   vec_t  tv [11];
   beat_t eq [$];
   beat_t exb;
   logic  rnd_en;

   initial begin
      #1000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      tv[0]  = '{0, 3, 32'h10203000, 4, 32'h00000060, 1'b0};
      tv[1]  = '{0, 4, 32'hFFFFFFFF, 4, 32'h000003FC, 1'b0};
      tv[2]  = '{0, 1, 32'h7F000000, 4, 32'h0000007F, 1'b0};
      tv[3]  = '{1, 2, 32'h01FF0000, 4, 32'h00010000, 1'b0};
      tv[4]  = '{1, 3, 32'h12345600, 4, 32'h9C000000, 1'b0};
      tv[5]  = '{2, 2, 32'hF0200000, 1, 32'h10000000, 1'b1};
      tv[6]  = '{3, 2, 32'hF0200000, 1, 32'hFF000000, 1'b1};
      tv[7]  = '{2, 1, 32'h05000000, 1, 32'h05000000, 1'b0};
      tv[8]  = '{3, 2, 32'h80800000, 1, 32'hFF000000, 1'b1};
      tv[9]  = '{3, 2, 32'h7F800000, 1, 32'hFF000000, 1'b0};
      tv[10] = '{2, 3, 32'hFF010100, 1, 32'h01000000, 1'b1};

      for (int k = 0; k < 4; k++) begin
         vin[k]  = 1'b0;
         rout[k] = 1'b1;
      end

      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("rst_ready_in%0d", k), ri[k], 1);
         chk($sformatf("rst_valid_out%0d", k), vo[k], 0);
      end
      chk("rst_out0", {dout[0], eo[0], er[0]}, 0);
      reset = 1'b0;
      @(posedge clk);
      #1;

      for (int i = 0; i < 11; i++) begin
         clear_q();
         send_pkt(tv[i].sel, tv[i].nin, tv[i].din);
         wait_beats(tv[i].sel, tv[i].nout, 40);
         for (int b = 0; b < tv[i].nout; b++) begin
            exb = '{tv[i].dexp[31-8*b -: 8], (b == tv[i].nout-1), (b == tv[i].nout-1) && tv[i].err};
            if (b < q[tv[i].sel].size())
               chk($sformatf("tv%0d_beat%0d", i, b), q[tv[i].sel][b], exb);
         end
         if (q[tv[i].sel].size() > 0)
            chk($sformatf("tv%0d_latency", i), qc[tv[i].sel][0] - end_cyc, 1);
      end

      // Three 1-beat packets against a stalled sink: second end parks, third waits.
      clear_q();
      rout[0] = 1'b0;
      send_beat(0, 8'h05, 1'b1);
      chk("ready_after_first", ri[0], 1);
      send_beat(0, 8'h06, 1'b1);
      fork
         send_beat(0, 8'h07, 1'b1);
         begin
            @(negedge clk);
            chk("held_ready_low", ri[0], 0);
            repeat (10) @(posedge clk);
            #1;
            rout[0] = 1'b1;
         end
      join
      wait_beats(0, 12, 60);
      for (int b = 0; b < 12 && b < q[0].size(); b++) begin
         exb = '{((b % 4) == 3) ? 8'(5 + b / 4) : 8'h00, ((b % 4) == 3), 1'b0};
         chk($sformatf("overlap_beat%0d", b), q[0][b], exb);
      end

      // Random packets under random backpressure against a sum model.
      clear_q();
      eq.delete();
      rnd_en = 1'b1;
      fork
         begin
            for (int p = 0; p < 200; p++) begin
               int          n;
               logic [31:0] s;
               logic [7:0]  d;
               n = $urandom_range(1, 4);
               s = 32'd0;
               for (int i = 0; i < n; i++) begin
                  d = 8'($urandom_range(0, 255));
                  s = s + {24'd0, d};
                  send_beat(0, d, (i == n-1));
               end
               for (int k = 0; k < 4; k++) eq.push_back('{s[31-8*k -: 8], (k == 3), 1'b0});
               if ($urandom_range(0, 3) == 0) begin
                  @(posedge clk);
                  #1;
               end
            end
            rnd_en = 1'b0;
         end
         begin
            while (rnd_en) begin
               @(posedge clk);
               #1;
               rout[0] = 1'($urandom_range(0, 1));
            end
            rout[0] = 1'b1;
         end
      join
      wait_beats(0, 800, 5000);
      for (int b = 0; b < eq.size() && b < q[0].size(); b++)
         chk($sformatf("rand_beat%0d", b), q[0][b], eq[b]);

      // Reset during the second output beat, then mid-packet, then a clean packet.
      clear_q();
      send_pkt(0, 2, 32'h11220000);
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_mid_send_valid", vo[0], 0);
      chk("rst_mid_send_ready", ri[0], 1);
      chk("rst_no_partial", q[0].size(), 1);
      reset = 1'b0;
      send_beat(0, 8'h40, 1'b0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      clear_q();
      send_pkt(0, 1, 32'h03000000);
      wait_beats(0, 4, 20);
      for (int b = 0; b < 4 && b < q[0].size(); b++) begin
         exb = '{(b == 3) ? 8'h03 : 8'h00, (b == 3), 1'b0};
         chk($sformatf("post_rst_beat%0d", b), q[0][b], exb);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/avst_packet_summer.md
# avst_packet_summer

Parametrised Avalon-ST packet checksum block: accumulates every data beat of an input packet into a SUM_W-bit sum, then emits that sum as a SUM_W/DATA_W-beat output packet. Accumulation and emission are decoupled, so the next input packet streams in while the previous sum drains. Sits inline after a packet source, producing per-packet sums for downstream checkers. Successor to the fixed 8-bit/32-bit adder: adds width, byte order, overflow/saturation and overlap.

## Interface
- DATA_W, 8, beat width in bits (input and output)
- SUM_W, 32, accumulator width; must be an integer multiple of DATA_W, ≥ DATA_W
- MSB_FIRST, 1, 1 = most-significant output beat first, 0 = least-significant first
- SATURATE, 0, 1 = clamp sum at all-ones on overflow, 0 = wrap modulo 2^SUM_W
- clk  input  1  single clock, all logic on rising edge
- reset  input  1  synchronous, active-high
- data_in  input  DATA_W  input beat, zero-extended to SUM_W before adding
- end_in  input  1  marks last beat of input packet
- valid_in  input  1  input beat valid
- ready_in  output  1  block can accept an input beat
- data_out  output  DATA_W  output beat (slice of sum)
- end_out  output  1  marks last output beat
- valid_out  output  1  output beat valid
- ready_out  input  1  sink accepts output beat
- error_out  output  1  overflow flag for the packet; qualified by valid_out && end_out

## Operation
- NBEATS = SUM_W/DATA_W. Input transfer = valid_in && ready_in; output transfer = valid_out && ready_out.
- Accumulator stage: acc (SUM_W), ovf (1). Non-end transfer: acc <= acc + data_in, ovf |= carry-out. SATURATE=1: on carry, acc <= all-ones.
- End transfer: final = acc + data_in (same overflow rule). If serializer idle, or its last beat transfers this same cycle: load serializer with final/ovf, clear acc/ovf. Otherwise park final in a hold register, set held=1.
- ready_in = !held (registered); never depends on valid_in.
- Serializer states: IDLE, SEND. Load -> SEND with beat index 0. Each output transfer advances index; transfer of beat NBEATS-1 -> IDLE, unless held=1, in which case hold register loads immediately (held clears, ready_in rises next cycle) and stays SEND.
- Beat k: MSB_FIRST=1 sends sum[SUM_W-1-k*DATA_W -: DATA_W]; MSB_FIRST=0 sends sum[k*DATA_W +: DATA_W].
- end_out = 1 only on beat NBEATS-1; error_out = packet ovf on that beat, else 0.
- Single-beat input packets legal. NBEATS=1 legal (each output beat has end_out=1).

## Timing
- Reset values: ready_in=1, valid_out=0, end_out=0, data_out=0, error_out=0; acc=0, ovf=0, held=0, serializer IDLE. Reset mid-packet or mid-send discards everything, no partial output.
- Latency: end transfer at cycle N -> first output beat valid at N+1 (serializer free).
- Output beat stable (data_out/end_out/error_out held) while valid_out=1 and ready_out=0.
- Back-to-back: with ready_out=1 constantly, output valid continuously; serializer free at cycle of last-beat transfer and may reload same cycle (zero bubble).
- held path: ready_in=0 from cycle after end transfer until cycle after serializer reloads from hold register.
- No combinational path valid_in->ready_in or ready_out->valid_out.

## Test plan
- Default params, input 0x10,0x20,0x30(end), ready_out=1 -> output 0x00,0x00,0x00,0x60, end_out on 4th, error_out=0, first beat 1 cycle after end beat.
- MSB_FIRST=0, input 0x01,0xFF(end) -> output 0x00,0x01,0x00,0x00 (sum 0x100 LSB first), end_out on 4th.
- DATA_W=8,SUM_W=8: inputs 0xF0,0x20(end) with SATURATE=0 -> 0x10, error_out=1; SATURATE=1 -> 0xFF, error_out=1.
- Three consecutive 1-beat packets 0x05,0x06,0x07 while ready_out=0 for 10 cycles -> ready_in drops after second end, all three sums emitted in order once ready_out=1, no loss.
- Random ready_out toggling over 200 random packets -> outputs match model, data stable during stalls.
- Assert reset during 2nd output beat -> next cycle valid_out=0, ready_in=1; new packet 0x03(end) yields sum 0x00000003.
